// File: rtl/cache_mem_pkg.sv
// Shared types and default constants for the cache memory side: the bus
// responder FSM states and the geometry defaults the controller and the
// datapath also build against.
package cache_mem_pkg;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } mem_state_t;

    // Default geometry shared across the cache subsystem.
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_LATENCY    = 4;
    localparam int DEF_DEPTH      = 256;

    // Bit width needed to index 'value' entries, never less than one bit so
    // that degenerate sizes still produce a legal vector.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/cache_mem_array.sv
// Backing store for the main-memory model: DEPTH words of DATA_W bits with
// one synchronous write port and one asynchronous (combinational) read port.
// Contents are deliberately not reset.
module cache_mem_array
    import cache_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int IDX_W  = clog2_min1(DEF_DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port: a word lands on the rising edge when we is high.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is combinational so a beat appears in the same cycle the
    // beat counter selects it.
    assign rdata = mem[raddr];

endmodule

// File: rtl/cache_main_memory.sv
// Main-memory model and bus responder for the cache controller. A request is
// captured in IDLE, held for LATENCY wait states, then either streamed back as
// a LINE_WORDS burst (read) or committed as one word (write). Every
// transaction ends with a single-cycle MDone pulse. Reset is asynchronous and
// active-low; all outputs are Moore-decoded from the state register, so they
// fall the moment reset asserts.
module cache_main_memory
    import cache_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int LATENCY    = DEF_LATENCY,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataIn,
    output logic [DATA_W-1:0] MDataOut,
    output logic              MRdy,
    output logic              MDone,
    output logic              MBusy
);

    // Word index into the array, beat-within-line index and wait counter.
    // The line offset bits are the low OFF_W bits of the word index, so the
    // array must hold more words than one line.
    localparam int IDX_W = clog2_min1(DEPTH);
    localparam int OFF_W = clog2_min1(LINE_WORDS);
    localparam int LAT_W = clog2_min1(LATENCY);

    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0] WAIT_LOAD = LAT_W'(LATENCY - 1);
    localparam logic [OFF_W-1:0] BEAT_ONE  = OFF_W'(1);
    localparam logic [LAT_W-1:0] WAIT_ONE  = LAT_W'(1);

    mem_state_t state_reg;
    mem_state_t state_next;

    logic [LAT_W-1:0]  wait_cnt_reg;
    logic [LAT_W-1:0]  wait_cnt_next;
    logic [OFF_W-1:0]  beat_reg;
    logic [OFF_W-1:0]  beat_next;

    // Request capture registers.
    logic              rw_reg;
    logic [IDX_W-1:0]  word_idx_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic              accept;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // Byte-offset bits never matter, and address bits above the array size
    // simply wrap, so they are intentionally left unused.
    logic unused_byte_offset;
    assign unused_byte_offset = ^MAddr[1:0];

    generate
        if (ADDR_W - 2 > IDX_W) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^MAddr[ADDR_W-1:IDX_W+2];
        end
    endgenerate

    // A request is only ever taken from IDLE; strobes in any other state,
    // including DONE, are ignored.
    assign accept = (state_reg == IDLE) && MStrobe;

    // State and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            beat_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_reg     <= beat_next;
        end
    end

    // Latch direction, word index (already reduced modulo DEPTH) and write
    // data when a request is accepted; they stay stable for the whole
    // transaction regardless of what the bus does afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_reg       <= 1'b0;
            word_idx_reg <= '0;
            wdata_reg    <= '0;
        end else if (accept) begin
            rw_reg       <= MRW;
            word_idx_reg <= MAddr[IDX_W+1:2];
            wdata_reg    <= MDataIn;
        end
    end

    // Next-state and counter sequencing.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_next     = beat_reg;
        unique case (state_reg)
            IDLE: begin
                if (MStrobe) begin
                    state_next    = WAIT;
                    wait_cnt_next = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (wait_cnt_reg == '0) begin
                    state_next = XFER;
                    beat_next  = '0;
                end else begin
                    wait_cnt_next = wait_cnt_reg - WAIT_ONE;
                end
            end
            XFER: begin
                // A write occupies exactly one XFER cycle; a read stays
                // until the last beat of the line has been presented.
                if (!rw_reg || (beat_reg == LAST_BEAT)) begin
                    state_next = DONE;
                end else begin
                    beat_next = beat_reg + BEAT_ONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Bus outputs: handshakes come straight from the state register, read
    // data is forced to zero outside read beats.
    always_comb begin
        MBusy    = (state_reg != IDLE);
        MRdy     = (state_reg == XFER);
        MDone    = (state_reg == DONE);
        MDataOut = '0;
        if ((state_reg == XFER) && rw_reg) begin
            MDataOut = mem_rdata;
        end
    end

    // The write is committed on the edge that closes the write XFER cycle.
    // Because reset clears the state asynchronously, an aborted write never
    // reaches that edge.
    assign mem_we = (state_reg == XFER) && !rw_reg;

    // Line-aligned burst address: the low OFF_W bits of the captured word
    // index are replaced by the beat number, which equals base + beat since
    // the base is line-aligned.
    assign mem_raddr = {word_idx_reg[IDX_W-1:OFF_W], beat_reg};

    cache_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .waddr (word_idx_reg),
        .wdata (wdata_reg),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_cache_main_memory.sv
// Self-checking bench for cache_main_memory: table-driven directed
// transactions, hand-written reset/strobe corner cases, a latency sweep on two
// extra instances, and randomized traffic against a word-array model.
module tb_cache_main_memory;
    import cache_mem_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 32;
    localparam int LW  = 4;
    localparam int LAT = 4;
    localparam int DEP = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          strobe;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          rdy;
    logic          done;
    logic          busy;

    // Extra instances for the latency sweep.
    logic          s1, s7;
    logic [DW-1:0] d1, d7;
    logic          r1, r7, dn1, dn7, b1, b7;

    cache_main_memory #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .LATENCY(LAT), .DEPTH(DEP)
    ) dut (
        .clk(clk), .reset(reset), .MStrobe(strobe), .MRW(rw), .MAddr(addr),
        .MDataIn(din), .MDataOut(dout), .MRdy(rdy), .MDone(done), .MBusy(busy)
    );

    cache_main_memory #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .LATENCY(1), .DEPTH(DEP)
    ) dut_l1 (
        .clk(clk), .reset(reset), .MStrobe(s1), .MRW(1'b1), .MAddr(16'h0000),
        .MDataIn(32'h0), .MDataOut(d1), .MRdy(r1), .MDone(dn1), .MBusy(b1)
    );

    cache_main_memory #(
        .ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW), .LATENCY(7), .DEPTH(DEP)
    ) dut_l7 (
        .clk(clk), .reset(reset), .MStrobe(s7), .MRW(1'b1), .MAddr(16'h0000),
        .MDataIn(32'h0), .MDataOut(d7), .MRdy(r7), .MDone(dn7), .MBusy(b7)
    );

    int errors = 0;
    int checks = 0;

    // Reference memory: word array plus a written flag per word.
    logic [DW-1:0] mdl_mem   [DEP];
    bit            mdl_valid [DEP];

    typedef struct {
        bit                    rw;
        logic [AW-1:0]         addr;
        logic [DW-1:0]         wdata;
        logic [LW-1:0][DW-1:0] exp_words;
        logic [LW-1:0]         emask;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int widx(input logic [AW-1:0] a);
        return (int'(a) >> 2) % DEP;
    endfunction

    // Expected burst for a read, from the model; unwritten words are masked.
    task automatic build_exp(input logic [AW-1:0] a,
                             output logic [LW-1:0][DW-1:0] ew,
                             output logic [LW-1:0] em);
        int base;
        base = (widx(a) / LW) * LW;
        ew = '0;
        em = '0;
        for (int b = 0; b < LW; b++) begin
            int idx;
            idx = (base + b) % DEP;
            if (mdl_valid[idx]) begin
                ew[b] = mdl_mem[idx];
                em[b] = 1'b1;
            end
        end
    endtask

    // Run one transaction starting in an IDLE cycle (cycle 0) and check every
    // cycle against the timing rules; returns in the following IDLE cycle.
    task automatic run_txn(input bit r, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [LW-1:0][DW-1:0] ew, input logic [LW-1:0] em,
                           input string tag);
        int total;
        total = r ? (LAT + LW + 1) : (LAT + 2);
        strobe = 1'b1; rw = r; addr = a; din = d;
        chk1($sformatf("%s c0 busy", tag), busy, 1'b0);
        tick();
        // Scramble the bus after capture; the DUT must not care.
        strobe = 1'b0; rw = 1'($urandom); addr = AW'($urandom); din = $urandom;
        for (int c = 1; c <= total; c++) begin
            bit exp_rdy;
            exp_rdy = r ? (c >= LAT + 1 && c <= LAT + LW) : (c == LAT + 1);
            chk1($sformatf("%s c%0d busy", tag, c), busy, 1'b1);
            chk1($sformatf("%s c%0d rdy", tag, c), rdy, exp_rdy);
            chk1($sformatf("%s c%0d done", tag, c), done, (c == total));
            if (r && exp_rdy) begin
                int beat;
                beat = c - LAT - 1;
                if (em[beat]) chk($sformatf("%s beat%0d data", tag, beat), dout, ew[beat]);
            end else if (!exp_rdy) begin
                chk($sformatf("%s c%0d dout idle", tag, c), dout, 32'h0);
            end
            tick();
        end
        chk1($sformatf("%s end busy", tag), busy, 1'b0);
        if (!r) begin
            mdl_mem[widx(a)]   = d;
            mdl_valid[widx(a)] = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0][DW-1:0] ew;
        logic [LW-1:0]         em;
        bit                    seen;
        int                    ndone;
        int                    f1, f7, dc1, dc7;

        reset = 1'b1; strobe = 1'b0; rw = 1'b0; addr = '0; din = '0;
        s1 = 1'b0; s7 = 1'b0;
        for (int i = 0; i < DEP; i++) mdl_valid[i] = 1'b0;

        vecs[0] = '{1'b0, 16'h0040, 32'hA0, '0, '0};
        vecs[1] = '{1'b0, 16'h0044, 32'hA1, '0, '0};
        vecs[2] = '{1'b0, 16'h0048, 32'hA2, '0, '0};
        vecs[3] = '{1'b0, 16'h004C, 32'hA3, '0, '0};
        vecs[4] = '{1'b1, 16'h0048, 32'h0, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 4'b1111};
        vecs[5] = '{1'b0, 16'h0400, 32'h55, '0, '0};
        vecs[6] = '{1'b1, 16'h0000, 32'h0, {32'h0, 32'h0, 32'h0, 32'h55}, 4'b0001};
        vecs[7] = '{1'b0, 16'h03FE, 32'hDEAD, '0, '0};
        vecs[8] = '{1'b1, 16'h03F0, 32'h0, {32'hDEAD, 32'h0, 32'h0, 32'h0}, 4'b1000};

        // Reset held with a pending strobe: nothing moves.
        #2 reset = 1'b0;
        strobe = 1'b1; rw = 1'b0; addr = 16'h0020; din = 32'h1234;
        repeat (3) tick();
        chk1("reset busy", busy, 1'b0);
        chk1("reset rdy", rdy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk("reset dout", dout, 32'h0);
        @(posedge clk); #1 reset = 1'b1;
        chk1("release idle", busy, 1'b0);
        tick();
        chk1("release accept", busy, 1'b1);
        strobe = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk1("release done seen", seen, 1'b1);
        tick();
        chk1("release back idle", busy, 1'b0);
        mdl_mem[widx(16'h0020)] = 32'h1234;
        mdl_valid[widx(16'h0020)] = 1'b1;

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_words,
                    vecs[i].emask, $sformatf("vec%0d", i));
        end

        // Strobes during WAIT and DONE of a read are ignored.
        strobe = 1'b1; rw = 1'b1; addr = 16'h0040;
        tick();
        ndone = 0;
        for (int c = 1; c <= LAT + LW + 7; c++) begin
            strobe = (c == 2) || (c == LAT + LW + 1);
            if (done) ndone++;
            if (c > LAT + LW + 1) chk1($sformatf("busystrobe c%0d busy", c), busy, 1'b0);
            tick();
        end
        strobe = 1'b0;
        chk("busystrobe done count", 32'(ndone), 32'd1);

        // Reset during beat 2 of a read.
        strobe = 1'b1; rw = 1'b1; addr = 16'h0040;
        tick();
        strobe = 1'b0;
        repeat (LAT + 2) tick();
        chk1("midburst rdy before", rdy, 1'b1);
        chk("midburst beat2", dout, 32'hA2);
        #3 reset = 1'b0;
        #1;
        chk1("midburst rdy", rdy, 1'b0);
        chk1("midburst busy", busy, 1'b0);
        chk("midburst dout", dout, 32'h0);
        chk1("midburst done", done, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) ndone++;
            chk1($sformatf("midburst after%0d busy", i), busy, 1'b0);
        end
        chk("midburst no done", 32'(ndone), 32'd0);

        // Reset mid-WAIT of a write leaves memory untouched.
        run_txn(1'b0, 16'h0010, 32'h11, '0, '0, "prewrite");
        strobe = 1'b1; rw = 1'b0; addr = 16'h0010; din = 32'h77;
        tick();
        strobe = 1'b0;
        tick();
        chk1("midwait busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk1("midwait busy drop", busy, 1'b0);
        tick();
        reset = 1'b1;
        build_exp(16'h0010, ew, em);
        run_txn(1'b1, 16'h0010, 32'h0, ew, em, "midwait read");

        // Latency sweep on the LATENCY=1 and LATENCY=7 instances.
        s1 = 1'b1; s7 = 1'b1;
        f1 = -1; f7 = -1; dc1 = -1; dc7 = -1;
        for (int c = 0; c < 30; c++) begin
            if (r1 && f1 < 0) f1 = c;
            if (r7 && f7 < 0) f7 = c;
            if (dn1 && dc1 < 0) dc1 = c;
            if (dn7 && dc7 < 0) dc7 = c;
            tick();
            s1 = 1'b0; s7 = 1'b0;
        end
        chk("lat1 first rdy", 32'(f1), 32'd2);
        chk("lat7 first rdy", 32'(f7), 32'd8);
        chk("lat1 done", 32'(dc1), 32'd6);
        chk("lat7 done", 32'(dc7), 32'd12);
        chk1("lat1 idle", b1, 1'b0);
        chk1("lat7 idle", b7, 1'b0);

        // Randomized traffic against the model (range spans the wrap).
        for (int i = 0; i < 60; i++) begin
            bit            rr;
            logic [AW-1:0] ra;
            logic [DW-1:0] rd;
            rr = 1'($urandom);
            ra = AW'($urandom_range(0, 16'h07FF));
            rd = $urandom;
            if (rr) build_exp(ra, ew, em);
            else begin ew = '0; em = '0; end
            run_txn(rr, ra, rd, ew, em, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_main_memory.md
# cache_main_memory

Main-memory model and bus responder for the cache controller's memory side. It accepts a request on `MStrobe`/`MRW` and inserts a fixed number of wait states. It then returns a full cache line as a word burst for read misses, or commits a single write-through word for writes. It closes every transaction with a one-cycle `MDone` pulse, which lets the controller's line-fill counter and ready logic sequence against it.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width of `MAddr`.
- `DATA_W`, 32: word width.
- `LINE_WORDS`, 4: words per cache line. Must be a power of two and at least 2.
- `LATENCY`, 4: wait-state cycles before the first beat. Must be at least 1.
- `DEPTH`, 256: words of backing storage. Must be a power of two.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `MStrobe`, in, 1: request strobe, sampled only in IDLE.
- `MRW`, in, 1: 1 = line read, 0 = single-word write.
- `MAddr`, in, `ADDR_W`: byte address of the request.
- `MDataIn`, in, `DATA_W`: write data, captured with the request.
- `MDataOut`, out, `DATA_W`: read beat data; 0 whenever `MRdy` is low.
- `MRdy`, out, 1: beat valid (read) or write committed (write).
- `MDone`, out, 1: one-cycle pulse ending each transaction.
- `MBusy`, out, 1: high in every state other than IDLE.

## Operation
- States: IDLE, WAIT, XFER, DONE.
- IDLE:
  - On `MStrobe=1`, capture `MRW`, `MAddr` and `MDataIn`, then go to WAIT.
  - Load the wait counter with `LATENCY-1`.
- WAIT:
  - Decrement the wait counter each cycle.
  - When the counter reaches 0, go to XFER and clear the beat counter.
- XFER, read (`MRW=1`):
  - The base word index is `MAddr[ADDR_W-1:2]` with its low `log2(LINE_WORDS)` bits forced to 0. Requests are line-aligned and no critical-word-first ordering is used.
  - On each cycle, drive `MRdy=1` and `MDataOut = mem[(base+beat) mod DEPTH]`, then increment `beat`.
  - After beat `LINE_WORDS-1`, go to DONE.
- XFER, write (`MRW=0`):
  - Hold XFER for one cycle with `MRdy=1`.
  - Write the captured `MDataIn` to `mem[MAddr[ADDR_W-1:2] mod DEPTH]` on that cycle's closing edge, then go to DONE.
- DONE: assert `MDone=1` for one cycle, then return to IDLE.
- No back-to-back requests: `MStrobe` is ignored in every state except IDLE, including DONE. A request held high through DONE is accepted in the following IDLE cycle.
- Address handling: byte-offset bits `MAddr[1:0]` are ignored. Word indices wrap modulo `DEPTH` with no error.
- Storage contents are not reset; they are undefined until written.
- Reset (`reset=0`) at any time:
  - The FSM goes to IDLE, counters clear, and all outputs go to 0 immediately, without waiting for a clock edge.
  - A write is either fully committed (its XFER edge has already occurred) or not performed. Partial writes are not possible.

## Timing
- Cycle 0 is the IDLE cycle in which `MStrobe=1` is sampled.
- Cycles 1..`LATENCY`: WAIT, with `MBusy=1`.
- Read: cycles `LATENCY+1`..`LATENCY+LINE_WORDS` carry `MRdy=1` with beats 0..`LINE_WORDS-1` in order. `MDone=1` in cycle `LATENCY+LINE_WORDS+1`.
- Write: `MRdy=1` in cycle `LATENCY+1`; `MDone=1` in cycle `LATENCY+2`.
- The earliest next request is sampled in the cycle after `MDone`.
- Output decoding:
  - `MRdy`, `MDone` and `MBusy` are Moore outputs decoded from the state register; they are glitch-free relative to the inputs.
  - `MDataOut` is combinational from the array read port and the beat counter, gated by XFER.
- Reset values: `MDataOut=0`, `MRdy=0`, `MDone=0`, `MBusy=0`, state IDLE.

## Structure
- Package `cache_mem_pkg`:
  - State enum `mem_state_t` with values {IDLE, WAIT, XFER, DONE}.
  - Default constants for `DATA_W`, `LINE_WORDS`, `LATENCY` and `DEPTH`, shared with the cache controller and the datapath.
- Sub-module `cache_mem_array`: a `DEPTH`×`DATA_W` array with one synchronous write port and one asynchronous read port.
- The top level holds the FSM, the wait and beat counters, and the request capture registers.

## Test plan
- **Reset:** Assert `reset=0` with `MStrobe=1` -> all outputs are 0 and the FSM stays in IDLE. Release reset -> the request is accepted on the next edge.
- **Write then read line:**
  - Write 0xA0, 0xA1, 0xA2, 0xA3 to byte addresses 0x0040, 0x0044, 0x0048, 0x004C.
  - Each write shows `MRdy` in cycle 5 and `MDone` in cycle 6.
  - A read of 0x0048 then returns 0xA0, 0xA1, 0xA2, 0xA3 in cycles 5 through 8, with `MDone` in cycle 9.
- **Strobe while busy:** Pulse `MStrobe` during WAIT and during DONE of a read -> no second transaction occurs and exactly one `MDone` is seen.
- **Wrap-around:** With `DEPTH=256`, write 0x55 to byte address 0x0400 (word 256) -> a read of 0x0000 returns beat 0 = 0x55.
- **Reset mid-burst:**
  - Assert reset during beat 2 of a read -> `MRdy` and `MBusy` drop immediately, with no `MDone`.
  - Reset mid-WAIT of a write to 0x0010 with 0x77 -> a later read of 0x0010 does not return 0x77 unless that address was previously written with 0x77.
- **Latency sweep:** Run with `LATENCY` = 1 and 7 -> the first `MRdy` appears in cycles 2 and 8 respectively.
